alu_writeback_stage: RTL
========================

// Module: alu_writeback_stage
// PURPOSE
//  Writeback stage directly downstream of the ALU. Captures each ALU result
//  (Lower, Upper, opcode, destination registers) in a 2-entry FIFO and drains
//  it to the single register-file write port. Swap produces two writes in
//  consecutive cycles; every other valid op produces one write.
// PARAMETERS
//  DW        17  datapath width (ALU Lower/Upper width)
//  AW        4   register-file address width
//  ZERO_REG  1   1: writes to address 0 suppressed (wr_en stays 0); 0: normal
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  in_valid    in   1   ALU result valid
//  in_ready    out  1   stage can accept (FIFO not full)
//  in_op       in   4   ALUOp that produced the result
//  in_lower    in   DW  ALU Lower result
//  in_upper    in   DW  ALU Upper result (meaningful for swap only)
//  in_rd_lo    in   AW  destination of Lower
//  in_rd_hi    in   AW  destination of Upper (swap only)
//  wr_en       out  1   register-file write strobe
//  wr_addr     out  AW  register-file write address
//  wr_data     out  DW  register-file write data
//  busy        out  1   FIFO non-empty or swap upper write pending
// BEHAVIOUR
//  - Reset (async, rst=1): FIFO emptied, FSM -> LO, wr_en=0, wr_addr=0,
//    wr_data=0, in_ready=1, busy=0. Pending swap upper write discarded.
//  - Accept: in_valid && in_ready at a rising edge pushes one entry.
//    in_ready = !full, registered; while full, stays 0 even if a pop occurs
//    that edge (a push at full never happens). Push+pop on one edge allowed
//    when not full; count unchanged.
//  - Write ops: 0000 add, 0001 sub, 0100 mul, 0101 div, 0111 mov, 1001 and,
//    1011 or -> one write (rd_lo, lower). 1000 swap -> two writes. Any other
//    opcode: entry popped in one cycle, no write (wr_en=0).
//  - FSM on FIFO head, all wr_* registered:
//    LO: head valid: wr_en=1, wr_addr=rd_lo, wr_data=lower; swap -> HI (no
//        pop); other -> pop, stay LO. FIFO empty: wr_en=0, stay LO.
//    HI: wr_en=1, wr_addr=rd_hi, wr_data=upper; pop; -> LO.
//  - Latency: entry accepted at edge k -> its first write visible (wr_en=1)
//    in the cycle after edge k+1. Throughput 1 entry/cycle; swap 2 cycles.
//  - ZERO_REG=1 and wr_addr would be 0: wr_en=0, FSM sequencing unchanged.
//  - wr_addr/wr_data hold their last value while wr_en=0.
//  - Writes strictly in acceptance order; Lower before Upper for swap.
//  - busy = (count!=0) || (state==HI), combinational from registers.
// CONFIGURATION
//  ALU_WB_FLAGS_EN defined: extra outputs flag_zero, flag_neg (1 bit each,
//    registered, reset 0). Updated on the edge that issues a Lower write
//    (LO state, write op, incl. ZERO_REG-suppressed writes):
//    flag_zero = (lower==0), flag_neg = lower[DW-1]. Unchanged by swap Upper
//    write or dropped opcodes.
//  Not defined: ports and flag registers absent; all else identical.
// TESTING
//  1 add, lower=17'h00005, rd_lo=3 -> one cycle after accept edge+1: wr_en=1,
//    wr_addr=3, wr_data=5; next cycle wr_en=0 (no further input).
//  2 swap, lower=17'h0000A rd_lo=1, upper=17'h1FFFF rd_hi=2 -> wr (1,0x0000A)
//    then (2,0x1FFFF) on consecutive cycles; in_ready stays 1.
//  3 back-to-back swap,swap,add with in_valid held -> FIFO fills, in_ready=0
//    for >=1 cycle; 5 writes in order, no gap between writes, none lost.
//  4 opcode 4'b1111 then mov rd_lo=0 with ZERO_REG=1 -> no wr_en pulse at all;
//    busy returns 0 two cycles after last accept.
//  5 rst asserted mid-swap (state HI) -> outputs 0 immediately, upper write
//    never appears, in_ready=1, busy=0 after release.
//  6 ALU_WB_FLAGS_EN: sub lower=0 -> flag_zero=1; mul lower=17'h10000 ->
//    flag_zero=0, flag_neg=1; following swap upper=0 leaves flags unchanged.

Source files
------------

// File: rtl/alu_writeback_stage_if.sv
// rtl/alu_writeback_stage_if.sv - ALU result input and register-file write port bundle
interface alu_writeback_stage_if #(
    parameter int DW = 17,
    parameter int AW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [DW-1:0] in_lower;
    logic [DW-1:0] in_upper;
    logic [AW-1:0] in_rd_lo;
    logic [AW-1:0] in_rd_hi;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (
        output in_valid, in_op, in_lower, in_upper, in_rd_lo, in_rd_hi,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_op, in_lower, in_upper, in_rd_lo, in_rd_hi,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - 2-entry result FIFO draining to one register-file write port
// Optional flag_zero/flag_neg outputs enabled by defining ALU_WB_FLAGS_EN.
module alu_writeback_stage #(
    parameter int DW       = 17,
    parameter int AW       = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_writeback_stage_if.slave wb,
    output logic                 busy
`ifdef ALU_WB_FLAGS_EN
    ,
    output logic                 flag_zero,
    output logic                 flag_neg
`endif
);
    localparam logic [3:0] OP_SWAP = 4'b1000;

    typedef enum logic {LO, HI} state_t;

    typedef struct packed {
        logic [3:0]    op;
        logic [DW-1:0] lower;
        logic [DW-1:0] upper;
        logic [AW-1:0] rd_lo;
        logic [AW-1:0] rd_hi;
    } entry_t;

    function automatic logic is_single_write(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0100, 4'b0101,
            4'b0111, 4'b1001, 4'b1011: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    entry_t        mem [2];
    logic          wptr, rptr;
    logic [1:0]    count, count_n;
    state_t        state, state_n;
    logic          push, pop;
    entry_t        head;
    logic          head_valid;
    logic          lower_write;
    logic          wr_en_n;
    logic [AW-1:0] wr_addr_n;
    logic [DW-1:0] wr_data_n;

    assign head        = mem[rptr];
    assign head_valid  = (count != 2'd0);
    assign push        = wb.in_valid && wb.in_ready;
    assign lower_write = is_single_write(head.op) || (head.op == OP_SWAP);
    assign busy        = (count != 2'd0) || (state == HI);

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        wr_en_n   = 1'b0;
        wr_addr_n = wb.wr_addr;
        wr_data_n = wb.wr_data;
        case (state)
            LO: begin
                if (head_valid) begin
                    if (lower_write) begin
                        // Address-0 writes still sequence normally, only the strobe is dropped.
                        if (!(ZERO_REG != 0 && head.rd_lo == '0)) begin
                            wr_en_n   = 1'b1;
                            wr_addr_n = head.rd_lo;
                            wr_data_n = head.lower;
                        end
                        if (head.op == OP_SWAP) state_n = HI;
                        else                    pop     = 1'b1;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            HI: begin
                pop     = 1'b1;
                state_n = LO;
                if (!(ZERO_REG != 0 && head.rd_hi == '0)) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = head.rd_hi;
                    wr_data_n = head.upper;
                end
            end
            default: state_n = LO;
        endcase
        count_n = count + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= '{op: wb.in_op, lower: wb.in_lower, upper: wb.in_upper,
                           rd_lo: wb.in_rd_lo, rd_hi: wb.in_rd_hi};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LO;
            count       <= 2'd0;
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            wb.in_ready <= 1'b1;
            wb.wr_en    <= 1'b0;
            wb.wr_addr  <= '0;
            wb.wr_data  <= '0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            // Ready is registered from the next occupancy, so a pop while full frees the slot one cycle later.
            wb.in_ready <= (count_n != 2'd2);
            wb.wr_en    <= wr_en_n;
            wb.wr_addr  <= wr_addr_n;
            wb.wr_data  <= wr_data_n;
        end
    end

`ifdef ALU_WB_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_zero <= 1'b0;
            flag_neg  <= 1'b0;
        end else if (state == LO && head_valid && lower_write) begin
            flag_zero <= (head.lower == '0);
            flag_neg  <= head.lower[DW-1];
        end
    end
`endif
endmodule
